// File: rtl/bus_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs, one channel per device, presenting
// head-of-queue data, occupancy, threshold status and sticky error flags to the bus arbiter.
module bus_fifo_bank #(
    parameter int  drvrs   = 4,
    parameter int  pckg_sz = 16,
    parameter int  depth   = 8,
    parameter int  af_lvl  = 6,
    localparam int CW      = $clog2(depth + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         push,
    input  logic [drvrs*pckg_sz-1:0] D_push,
    input  logic [drvrs-1:0]         pop,
    output logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pndng,
    output logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         almost_full,
    output logic [drvrs*CW-1:0]      count,
    input  logic [drvrs-1:0]         flush,
    output logic [drvrs-1:0]         overflow,
    output logic [drvrs-1:0]         underflow
);
    localparam int            PW       = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);
    localparam logic [CW-1:0] CNT_AF   = CW'(af_lvl);

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    for (genvar g = 0; g < drvrs; g++) begin : g_ch
        logic [pckg_sz-1:0] mem_r [depth];
        logic [PW-1:0]      rd_ptr_r;
        logic [PW-1:0]      wr_ptr_r;
        logic [CW-1:0]      count_r;
        logic               ovf_r;
        logic               udf_r;
        logic               pndng_s;
        logic               full_s;
        logic               pop_ok_s;
        logic               push_ok_s;

        // Acceptance decisions; a full channel still takes a push when a pop frees a slot.
        always_comb begin
            pndng_s   = (count_r != '0);
            full_s    = (count_r == CNT_FULL);
            pop_ok_s  = pop[g] && pndng_s;
            push_ok_s = push[g] && (!full_s || pop_ok_s);
        end

        // Pointer, occupancy and sticky-flag state; reset and flush clear the channel.
        always_ff @(posedge clk) begin
            if (reset || flush[g]) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
                count_r  <= '0;
                ovf_r    <= 1'b0;
                udf_r    <= 1'b0;
            end else begin
                if (pop_ok_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
                if (push_ok_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                case ({push_ok_s, pop_ok_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
                if (push[g] && !push_ok_s) begin
                    ovf_r <= 1'b1;
                end
                if (pop[g] && !pndng_s) begin
                    udf_r <= 1'b1;
                end
            end
        end

        // Storage array; contents are irrelevant while the channel is empty.
        always_ff @(posedge clk) begin
            if (push_ok_s && !reset && !flush[g]) begin
                mem_r[wr_ptr_r] <= D_push[g*pckg_sz +: pckg_sz];
            end
        end

        assign D_pop[g*pckg_sz +: pckg_sz] = pndng_s ? mem_r[rd_ptr_r] : '0;
        assign pndng[g]                    = pndng_s;
        assign full[g]                     = full_s;
        assign almost_full[g]              = (count_r >= CNT_AF);
        assign count[g*CW +: CW]           = count_r;
        assign overflow[g]                 = ovf_r;
        assign underflow[g]                = udf_r;
    end
endmodule

// File: tb/tb_bus_fifo_bank.sv
// Scoreboard bench for bus_fifo_bank: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of each channel.
module tb_bus_fifo_bank;
    localparam int DRVRS = 4;
    localparam int PSZ   = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DRVRS-1:0]       push;
    logic [DRVRS*PSZ-1:0]   D_push;
    logic [DRVRS-1:0]       pop;
    logic [DRVRS*PSZ-1:0]   D_pop;
    logic [DRVRS-1:0]       pndng;
    logic [DRVRS-1:0]       full;
    logic [DRVRS-1:0]       almost_full;
    logic [DRVRS*CW-1:0]    count;
    logic [DRVRS-1:0]       flush;
    logic [DRVRS-1:0]       overflow;
    logic [DRVRS-1:0]       underflow;

    always #5 clk = ~clk;

    bus_fifo_bank #(.drvrs(DRVRS), .pckg_sz(PSZ), .depth(DEPTH), .af_lvl(AF)) dut (
        .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop), .D_pop(D_pop),
        .pndng(pndng), .full(full), .almost_full(almost_full), .count(count),
        .flush(flush), .overflow(overflow), .underflow(underflow)
    );

    logic [PSZ-1:0] model_q [DRVRS][$];
    logic [PSZ-1:0] exp_q   [DRVRS][$];
    bit             ovf_m   [DRVRS];
    bit             udf_m   [DRVRS];
    int             n_chk  = 0;
    int             n_pass = 0;
    bit             mon_en = 1'b0;
    int             m_sz;
    logic [PSZ-1:0] m_hd;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
    endtask

    // Reference model: apply the channel rules to the inputs seen at this clock edge.
    task automatic model_apply();
        for (int c = 0; c < DRVRS; c++) begin
            bit take_pop;
            bit take_push;
            if (reset || flush[c]) begin
                model_q[c].delete();
                exp_q[c].delete();
                ovf_m[c] = 1'b0;
                udf_m[c] = 1'b0;
            end else begin
                take_pop  = pop[c] && (model_q[c].size() > 0);
                take_push = push[c] && ((model_q[c].size() < DEPTH) || take_pop);
                if (pop[c] && model_q[c].size() == 0) udf_m[c] = 1'b1;
                if (push[c] && !take_push) ovf_m[c] = 1'b1;
                if (take_pop) void'(model_q[c].pop_front());
                if (take_push) begin
                    model_q[c].push_back(D_push[c*PSZ +: PSZ]);
                    exp_q[c].push_back(D_push[c*PSZ +: PSZ]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
        push  = '0;
        pop   = '0;
        flush = '0;
        reset = 1'b0;
    endtask

    task automatic set_push(input int c, input logic [PSZ-1:0] d);
        push[c] = 1'b1;
        D_push[c*PSZ +: PSZ] = d;
    endtask

    // Monitor: status against the model, popped words against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < DRVRS; c++) begin
                m_sz = model_q[c].size();
                m_hd = (m_sz > 0) ? model_q[c][0] : '0;
                chk("count", c, 32'(count[c*CW +: CW]), 32'(m_sz));
                chk("pndng", c, 32'(pndng[c]), 32'(m_sz > 0));
                chk("full", c, 32'(full[c]), 32'(m_sz == DEPTH));
                chk("almost_full", c, 32'(almost_full[c]), 32'(m_sz >= AF));
                chk("overflow", c, 32'(overflow[c]), 32'(ovf_m[c]));
                chk("underflow", c, 32'(underflow[c]), 32'(udf_m[c]));
                chk("head", c, 32'(D_pop[c*PSZ +: PSZ]), 32'(m_hd));
                if (pop[c] && pndng[c] && !reset && !flush[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_chk++;
                        $display("FAIL pop_data ch%0d: popped %0h with nothing expected", c, D_pop[c*PSZ +: PSZ]);
                    end else begin
                        chk("pop_data", c, 32'(D_pop[c*PSZ +: PSZ]), 32'(exp_q[c].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        push   = '0;
        pop    = '0;
        flush  = '0;
        D_push = '0;
        reset = 1'b1; tick();
        reset = 1'b1; tick();
        mon_en = 1'b1;
        repeat (10) tick();

        // Fill ch0 to full then drain in order.
        for (int i = 0; i < 8; i++) begin set_push(0, 16'hA000 + 16'(i)); tick(); end
        repeat (8) begin pop[0] = 1'b1; tick(); end

        // Overflow on ch1, then simultaneous push+pop while full.
        for (int i = 0; i < 8; i++) begin set_push(1, 16'hC100 + 16'(i)); tick(); end
        set_push(1, 16'hBEEF); tick();
        set_push(1, 16'hC1FF); pop[1] = 1'b1; tick();
        repeat (9) begin pop[1] = 1'b1; tick(); end

        // Underflow on ch2, then push+pop into an empty channel.
        pop[2] = 1'b1; tick();
        set_push(2, 16'h1234); pop[2] = 1'b1; tick();
        tick();
        pop[2] = 1'b1; tick();

        // Pointer wrap on ch3.
        for (int i = 0; i < 5; i++) begin set_push(3, 16'h3000 + 16'(i)); tick(); end
        repeat (5) begin pop[3] = 1'b1; tick(); end
        for (int i = 0; i < 8; i++) begin set_push(3, 16'h3100 + 16'(i)); tick(); end
        repeat (8) begin pop[3] = 1'b1; tick(); end

        // Flush one channel, then reset in the middle of a burst.
        for (int i = 0; i < 4; i++) begin
            set_push(0, 16'h4000 + 16'(i));
            if (i < 3) set_push(1, 16'h5000 + 16'(i));
            tick();
        end
        flush[0] = 1'b1; tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < DRVRS; c++) set_push(c, 16'h6000 + 16'(c * 16 + i));
            if (i == 2) reset = 1'b1;
            tick();
        end
        repeat (2) tick();

        // Randomized traffic with alternating fill/drain bias.
        for (int n = 0; n < 3000; n++) begin
            bit fill_ph;
            fill_ph = ((n / 200) % 2) == 0;
            for (int c = 0; c < DRVRS; c++) begin
                if ($urandom_range(0, 3) < (fill_ph ? 3 : 1)) set_push(c, 16'($urandom));
                if ($urandom_range(0, 3) < (fill_ph ? 1 : 3)) pop[c] = 1'b1;
                if ($urandom_range(0, 99) == 0) flush[c] = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            tick();
        end
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
